// File: rtl/quad_step_decoder_if.sv
// Encoder pins, load bus and decoded step/position outputs of the quadrature decoder.
interface quad_step_decoder_if #(parameter int LEN = 8);
  logic           enc_a;
  logic           enc_b;
  logic           load;
  logic [LEN-1:0] data;
  logic           step;
  logic           dir;
  logic           err;
  logic [LEN-1:0] count;

  modport master (output enc_a, enc_b, load, data, input step, dir, err, count);
  modport slave  (input enc_a, enc_b, load, data, output step, dir, err, count);
endinterface

// File: rtl/quad_step_decoder.sv
// x4 quadrature decoder: per-channel sync + glitch filter, Gray-code step decode,
// and a loadable wrapping position counter.
module qsd_filter #(
  parameter int FILTER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic prime_i,
  input  logic raw_i,
  output logic sync_o,
  output logic filt_o
);
  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

  logic          sync1_q, sync2_q, filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (prime_i) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else if (sync2_q != filt_q) begin
        // new level must persist FILTER sampled cycles before acceptance
        if (cnt_q == CNT_MAX) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign sync_o = sync2_q;
  assign filt_o = filt_q;
endmodule

module quad_step_decoder #(
  parameter int LEN    = 8,
  parameter int FILTER = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  quad_step_decoder_if.slave   bus
);
  localparam int PRIME_N = FILTER + 2;
  localparam int PW      = $clog2(PRIME_N + 1);

  logic [PW-1:0]  prime_q;
  logic           priming;
  logic [1:0]     raw, sync, filt;
  logic [1:0]     ab_q, ab_prev_q, diff;
  logic           step_d, err_d, up_d;
  logic           step_q, err_q, dir_q;
  logic [LEN-1:0] count_q, count_d;

  assign raw     = {bus.enc_a, bus.enc_b};
  assign priming = (prime_q != PW'(PRIME_N));

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      qsd_filter #(.FILTER(FILTER)) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .prime_i(priming),
        .raw_i  (raw[ch]),
        .sync_o (sync[ch]),
        .filt_o (filt[ch])
      );
    end
  endgenerate

  // {A,B} up order 00->10->11->01: moving up iff new A differs from old B
  always_comb begin
    diff    = ab_q ^ ab_prev_q;
    step_d  = !priming && ((diff == 2'b01) || (diff == 2'b10));
    err_d   = !priming && (diff == 2'b11);
    up_d    = ab_q[1] ^ ab_prev_q[0];
    count_d = count_q;
    if (bus.load)    count_d = bus.data;
    else if (step_d) count_d = up_d ? count_q + LEN'(1) : count_q - LEN'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q   <= '0;
      ab_q      <= '0;
      ab_prev_q <= '0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      dir_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      if (priming) begin
        // track the resting pin state so release never looks like a transition
        prime_q   <= prime_q + PW'(1);
        ab_q      <= sync;
        ab_prev_q <= sync;
      end else begin
        ab_q      <= filt;
        ab_prev_q <= ab_q;
      end
      step_q  <= step_d;
      err_q   <= err_d;
      if (step_d) dir_q <= up_d;
      count_q <= count_d;
    end
  end

  assign bus.step  = step_q;
  assign bus.err   = err_q;
  assign bus.dir   = dir_q;
  assign bus.count = count_q;
endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature front end that drives up/down counting from a rotary or linear encoder on the IO shield.
- Synchronises and glitch-filters the asynchronous A/B encoder pins.
- Decodes every Gray-code transition (x4 resolution) into a one-cycle step pulse with a direction bit, i.e. the enable/up_down pair a counter consumes.
- Also keeps its own loadable, wrapping position count and flags illegal transitions.

Parameters:
- LEN, 8: width of the position count and the load data.
- FILTER, 4: consecutive synchronised cycles a new pin level must hold before it is accepted. Legal range is FILTER >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enc_a  input  1  encoder channel A, asynchronous to clk.
- enc_b  input  1  encoder channel B, asynchronous to clk.
- load  input  1  synchronous load of count from data.
- data  input  LEN  value loaded into count.
- step  output  1  one-cycle pulse per accepted legal transition.
- dir  output  1  direction of the last step: 1 = up, 0 = down.
- err  output  1  one-cycle pulse per illegal (double) transition.
- count  output  LEN  current position.

Behaviour:
- Reset (asynchronous assert, synchronous release to clk): count=0, step=0, dir=0, err=0, synchronisers=0, filtered A/B=0, filter counters=0, prime counter=0.
- Synchroniser: two flops per channel. Nothing downstream uses the raw pins.
- Filter, per channel and independent:
  - Counter increments while the synchronised level differs from the filtered level.
  - Counter clears whenever they are equal.
  - When the counter has reached FILTER-1 and the levels still differ, the filtered level takes the synchronised value and the counter clears.
  - Any pulse shorter than FILTER synchronised cycles is discarded.
- Priming:
  - For the first FILTER+2 cycles after reset release, filtered A/B copy the synchronised A/B directly every cycle.
  - step and err stay 0 during priming.
  - This prevents a spurious step when the pins rest at a non-00 state at reset release.
- Decode: compare previous filtered {A,B} with new filtered {A,B} each cycle.
  - Up order is 00->10->11->01->00 (A leads B).
  - Down is the reverse order.
  - No change produces no output.
  - Both bits changing in the same cycle asserts err for one cycle; no step, count and dir unchanged.
- Outputs:
  - step, dir, err and count are all registered.
  - step is high for exactly one cycle per accepted transition.
  - dir updates on the same edge as step and holds until the next step.
- Latency: from the first rising edge that samples a new pin level to step high is FILTER+3 cycles. The count update is visible in the same cycle step is high.
- Count arithmetic:
  - Modulo 2^LEN: up from all-ones gives 0; down from 0 gives all-ones.
  - One LSB per step.
- load:
  - Highest priority; count <= data on that edge.
  - A step decoded in the same cycle still pulses step/dir, but is not applied to count. The loaded value wins.
  - load does not affect the synchronisers, filter or decoder.
- Reset mid-operation clears everything immediately and re-primes after release. There is no step on the first post-reset state.
- Transitions arriving faster than one per FILTER cycles per channel are not guaranteed to be counted. This is outside the operating range.

Test Plan:
- Reset with enc_a=enc_b=0, release, drive 00->10->11->01->00 with each state held 10 cycles → four step pulses with dir=1, count 0->4, err never set, first step exactly FILTER+3 cycles after the first change.
- Drive the reverse sequence from count=4 → four steps with dir=0, count back to 0. Then one more down step → count=255 (LEN=8).
- With count=255, one up step → count=0 and step pulses once.
- A high for 2 cycles (FILTER=4) while B held 0 → no step, no err, count unchanged. A high for 4+ cycles → exactly one step, dir=1.
- From 00, drive A and B high on the same edge and hold → one err pulse, no step, count unchanged. Then 11->01 → normal up step.
- Load data=0x80 on the exact cycle a step is decoded → step=1 that cycle, count=0x80 next cycle (not 0x81).
- Hold pins at 11, pulse rst_n low mid-run and release → count=0, no step and no err during or after priming. A following 11->01 produces one up step.
